serial_mag_comparator: RTL and testbench

//   Parametrised sequential successor of the 4-bit gate-level comparator: compares two

---
 rtl/cmp_pkg.sv | 21 ++
 rtl/cmp_slice.sv | 15 +
 rtl/serial_mag_comparator.sv | 129 ++++++++++++
 tb/tb_serial_mag_comparator.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared constants and state type for the serial magnitude comparator.
// Result codes are one-hot {eq,gt,lt}; CMP_NONE is the idle/cleared value.
package cmp_pkg;

   localparam logic [2:0] CMP_EQ   = 3'b100;
   localparam logic [2:0] CMP_GT   = 3'b010;
   localparam logic [2:0] CMP_LT   = 3'b001;
   localparam logic [2:0] CMP_NONE = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   // A single-slice configuration still needs a 1-bit index register
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational SLICE-bit unsigned magnitude comparator producing a one-hot {eq,gt,lt}.
module cmp_slice
   import cmp_pkg::*;
#(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] i_a,
   input  logic [SLICE-1:0] i_b,
   output logic [2:0]       o_c
);

   assign o_c = (i_a == i_b) ? CMP_EQ :
                (i_a >  i_b) ? CMP_GT : CMP_LT;

endmodule

// File: rtl/serial_mag_comparator.sv
// Sequential WIDTH-bit comparator, SLICE bits per cycle MSB first, early exit on first difference.
// Optional macro SIGNED_CMP_EN adds the cmp_signed port for two's-complement ordering.
module serial_mag_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SIGNED_CMP_EN
   input  logic             cmp_signed,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       c
);

   localparam int                 N        = WIDTH / SLICE;
   localparam int                 IDX_W    = idxWidth(N);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N - 1);

   if ((SLICE < 1) || (SLICE > WIDTH)) begin : g_badSlice
      $error("serial_mag_comparator: SLICE must satisfy 1 <= SLICE <= WIDTH");
   end
   if ((WIDTH % SLICE) != 0) begin : g_badWidth
      $error("serial_mag_comparator: WIDTH must be a multiple of SLICE");
   end

   state_t             r_state;
   state_t             w_nextState;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   w_loadA;
   logic [WIDTH-1:0]   w_loadB;
   logic [IDX_W-1:0]   r_idx;
   logic [2:0]         r_c;
   logic [2:0]         w_sliceC;
   logic               w_lastSlice;
   logic               w_finish;

   // Operands shift left each RUN cycle, so the active slice is always the top SLICE bits
   cmp_slice #(
      .SLICE(SLICE)
   ) u_slice (
      .i_a (r_a[WIDTH-1 -: SLICE]),
      .i_b (r_b[WIDTH-1 -: SLICE]),
      .o_c (w_sliceC)
   );

   assign w_lastSlice = (r_idx == LAST_IDX);
   assign w_finish    = (w_sliceC != CMP_EQ) || w_lastSlice;

   // Flipping both sign bits maps two's-complement order onto unsigned order
   always_comb begin
      w_loadA = a;
      w_loadB = b;
`ifdef SIGNED_CMP_EN
      if (cmp_signed) begin
         w_loadA[WIDTH-1] = ~a[WIDTH-1];
         w_loadB[WIDTH-1] = ~b[WIDTH-1];
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)  w_nextState = ST_RUN;
         ST_RUN:  if (w_finish)  w_nextState = ST_DONE;
         ST_DONE: if (out_ready) w_nextState = ST_IDLE;
         default:                w_nextState = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      out_valid = (r_state == ST_DONE);
      c         = r_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_idx <= '0;
         r_c   <= CMP_NONE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a   <= w_loadA;
                  r_b   <= w_loadB;
                  r_idx <= '0;
               end
            end
            ST_RUN: begin
               if (w_finish) begin
                  r_c <= w_sliceC;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
                  r_a   <= r_a << SLICE;
                  r_b   <= r_b << SLICE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_c   <= CMP_NONE;
                  r_idx <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench: cycle-level behavioural model plus directed vectors for 16/4 and 16/16 builds.
module tb_serial_mag_comparator;

   localparam int MW = 16;
   localparam int MS = 4;
   localparam int MN = MW / MS;

   logic        clk;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a, b;
   logic        sgn;
   logic [2:0]  c;

   logic        in_valid16, in_ready16, out_valid16, out_ready16;
   logic [15:0] a16, b16;
   logic [2:0]  c16;

   int          checkCount;
   int          passCount;
   int          cycleCount;

   int          mPhase;
   int          mWait;
   logic [2:0]  mResult;

   serial_mag_comparator #(.WIDTH(16), .SLICE(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
`ifdef SIGNED_CMP_EN
      .cmp_signed (sgn),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .c          (c)
   );

   serial_mag_comparator #(.WIDTH(16), .SLICE(16)) dut16 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid16),
      .in_ready   (in_ready16),
      .a          (a16),
      .b          (b16),
`ifdef SIGNED_CMP_EN
      .cmp_signed (1'b0),
`endif
      .out_valid  (out_valid16),
      .out_ready  (out_ready16),
      .c          (c16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
   endtask

   function automatic logic [2:0] refResult(input logic [15:0] x, input logic [15:0] y, input logic s);
      if (x == y) return 3'b100;
      if (s) return ($signed(x) > $signed(y)) ? 3'b010 : 3'b001;
      return (x > y) ? 3'b010 : 3'b001;
   endfunction

   // Cycles from accept to out_valid: 2 + index of the first differing 4-bit slice, or N+1 if equal
   function automatic int refLatency(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] d;
      d = x ^ y;
      for (int k = 0; k < MN; k++) begin
         if (((d >> (MW - MS * (k + 1))) & 16'h000F) != 16'h0000) return 2 + k;
      end
      return MN + 1;
   endfunction

   // Model phases: 0 idle, 1 waiting for the result, 2 result presented
   task automatic modelAdvance();
      if (!rst_n) begin
         mPhase  = 0;
         mWait   = 0;
         mResult = 3'b000;
      end else begin
         case (mPhase)
            0: if (in_valid) begin
               mResult = refResult(a, b, sgn);
               mWait   = refLatency(a, b) - 1;
               mPhase  = 1;
            end
            1: begin
               mWait--;
               if (mWait == 0) mPhase = 2;
            end
            default: if (out_ready) begin
               mPhase  = 0;
               mResult = 3'b000;
            end
         endcase
      end
   endtask

   task automatic modelCompare();
      checkOutput("model_in_ready",  32'(in_ready),  32'(mPhase == 0));
      checkOutput("model_out_valid", 32'(out_valid), 32'(mPhase == 2));
      checkOutput("model_c",         32'(c),         32'((mPhase == 2) ? mResult : 3'b000));
   endtask

   task automatic tick();
      modelAdvance();
      @(negedge clk);
      cycleCount++;
      modelCompare();
   endtask

   task automatic applyStimulus(input string name, input logic [15:0] x, input logic [15:0] y,
                                input logic s, input int hold, input logic [2:0] expC, input int expLat);
      int   lat;
      logic sawReady;
      out_ready = (hold == 0);
      in_valid  = 1'b1;
      a = x; b = y; sgn = s;
      tick();
      in_valid = 1'b0;
      a = ~x; b = x; sgn = ~s;
      lat = 1;
      sawReady = 1'b0;
      while (!out_valid && lat < 40) begin
         if (in_ready) sawReady = 1'b1;
         tick();
         lat++;
      end
      checkOutput({name, "_latency"},   32'(lat),      32'(expLat));
      checkOutput({name, "_c"},         32'(c),        32'(expC));
      checkOutput({name, "_ready_low"}, 32'(sawReady), 32'(0));
      for (int i = 0; i < hold; i++) begin
         tick();
         checkOutput({name, "_hold_c"},     32'(c),         32'(expC));
         checkOutput({name, "_hold_valid"}, 32'(out_valid), 32'(1));
         checkOutput({name, "_hold_ready"}, 32'(in_ready),  32'(0));
      end
      out_ready = 1'b1;
      tick();
      checkOutput({name, "_release"}, 32'({in_ready, out_valid, c}), 32'(5'b10000));
      sgn = 1'b0;
   endtask

   initial begin
      logic [15:0] ta[5];
      logic [15:0] tb[5];
      logic [2:0]  tc[5];
      int          tl[5];
      logic [15:0] pa, pb;
      logic [2:0]  pc;
      int          w, acceptCycle, prevAccept, validSeen;

      checkCount = 0; passCount = 0; cycleCount = 0;
      mPhase = 0; mWait = 0; mResult = 3'b000;
      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; sgn = 1'b0; out_ready = 1'b1;
      in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b1;

      tick();
      tick();
      checkOutput("reset_in_ready",    32'(in_ready),   32'(1));
      checkOutput("reset_out_valid",   32'(out_valid),  32'(0));
      checkOutput("reset_c",           32'(c),          32'(0));
      checkOutput("reset16_in_ready",  32'(in_ready16), 32'(1));
      rst_n = 1'b1;
      tick();

      $display("[TB] directed spec vectors");
      applyStimulus("eq_1234",      16'h1234, 16'h1234, 1'b0, 0,  3'b100, 5);
      applyStimulus("gt_8000",      16'h8000, 16'h7FFF, 1'b0, 0,  3'b010, 2);
`ifdef SIGNED_CMP_EN
      applyStimulus("signed_8000",  16'h8000, 16'h7FFF, 1'b1, 0,  3'b001, 2);
      applyStimulus("signed_neg1",  16'hFFFF, 16'h0001, 1'b1, 0,  3'b001, 2);
`endif
      applyStimulus("lt_lastslice", 16'h12F4, 16'h12F5, 1'b0, 0,  3'b001, 5);
      applyStimulus("backpressure", 16'h0005, 16'h0003, 1'b0, 10, 3'b010, 5);

      ta[0] = 16'h0000; tb[0] = 16'h0000; tc[0] = 3'b100; tl[0] = 5;
      ta[1] = 16'hFFFF; tb[1] = 16'hFFFF; tc[1] = 3'b100; tl[1] = 5;
      ta[2] = 16'h0100; tb[2] = 16'h0200; tc[2] = 3'b001; tl[2] = 3;
      ta[3] = 16'h00F0; tb[3] = 16'h00E0; tc[3] = 3'b010; tl[3] = 4;
      ta[4] = 16'hA000; tb[4] = 16'h5FFF; tc[4] = 3'b010; tl[4] = 2;
      for (int i = 0; i < 5; i++) begin
         applyStimulus($sformatf("table%0d", i), ta[i], tb[i], 1'b0, 0, tc[i], tl[i]);
      end

      $display("[TB] reset while running");
      in_valid = 1'b1; a = 16'hFFFF; b = 16'h0000;
      tick();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("rstrun_in_ready",  32'(in_ready),  32'(1));
      checkOutput("rstrun_out_valid", 32'(out_valid), 32'(0));
      checkOutput("rstrun_c",         32'(c),         32'(0));
      tick();
      rst_n = 1'b1;
      validSeen = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (out_valid) validSeen++;
      end
      checkOutput("rstrun_no_pulse", 32'(validSeen), 32'(0));

      $display("[TB] reset while holding a result");
      out_ready = 1'b0;
      in_valid = 1'b1; a = 16'hFFFF; b = 16'h0000;
      tick();
      in_valid = 1'b0;
      tick();
      checkOutput("rstdone_pre_valid", 32'(out_valid), 32'(1));
      checkOutput("rstdone_pre_c",     32'(c),         32'(3'b010));
      rst_n = 1'b0;
      #1;
      checkOutput("rstdone_in_ready",  32'(in_ready),  32'(1));
      checkOutput("rstdone_out_valid", 32'(out_valid), 32'(0));
      checkOutput("rstdone_c",         32'(c),         32'(0));
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      tick();

      $display("[TB] SLICE=16 back-to-back");
      ta[0] = 16'h0000; tb[0] = 16'h0000; tc[0] = 3'b100;
      ta[1] = 16'hFFFF; tb[1] = 16'h0000; tc[1] = 3'b010;
      ta[2] = 16'h1234; tb[2] = 16'h1235; tc[2] = 3'b001;
      ta[3] = 16'h8000; tb[3] = 16'h7FFF; tc[3] = 3'b010;
      ta[4] = 16'hABCD; tb[4] = 16'hABCD; tc[4] = 3'b100;
      in_valid16 = 1'b1;
      out_ready16 = 1'b1;
      prevAccept = 0;
      for (int i = 0; i < 11; i++) begin
         if (i < 5) begin
            pa = ta[i]; pb = tb[i]; pc = tc[i];
         end else begin
            pa = 16'($urandom());
            pb = (i == 7) ? pa : 16'($urandom());
            pc = refResult(pa, pb, 1'b0);
         end
         a16 = pa; b16 = pb;
         w = 0;
         while (!in_ready16 && w < 10) begin
            tick();
            w++;
         end
         checkOutput("s16_accept_ready", 32'(in_ready16), 32'(1));
         acceptCycle = cycleCount;
         if (i > 0) checkOutput("s16_spacing", 32'(acceptCycle - prevAccept), 32'(3));
         prevAccept = acceptCycle;
         tick();
         checkOutput("s16_run_valid", 32'(out_valid16), 32'(0));
         a16 = ~pa; b16 = pa;
         tick();
         checkOutput("s16_lat2_valid", 32'(out_valid16), 32'(1));
         checkOutput("s16_c",          32'(c16),         32'(pc));
      end
      in_valid16 = 1'b0;
      tick();
      tick();

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
